// File: rtl/fetch_mem_pkg.sv
// rtl/fetch_mem_pkg.sv - shared types and instruction field positions for the fetch/memory unit
package fetch_mem_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH_WAIT = 2'd1,
        DATA_WAIT  = 2'd2
    } fm_state_e;

    // 16-bit instruction encoding; consumed by downstream decode, not by this unit
    localparam int CTRL_MSB = 15;
    localparam int CTRL_LSB = 12;
    localparam int REGA_MSB = 11;
    localparam int REGA_LSB = 8;
    localparam int REGB_MSB = 7;
    localparam int REGB_LSB = 4;
    localparam int REGD_MSB = 3;
    localparam int REGD_LSB = 0;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

endpackage

// File: rtl/fetch_mem_unit_pc_reg.sv
// rtl/fetch_mem_unit_pc_reg.sv - program counter with reset, load and increment
module pc_reg
    import fetch_mem_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0,
    parameter int PC_INC   = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // load beats increment; the add wraps naturally at ADDR_W bits
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(PC_INC);
        end
    end

    // reset has the highest priority of all
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_mem_unit.sv
// rtl/fetch_mem_unit.sv - PC/IR/MDR datapath with req/ack memory port and access FSM
module fetch_mem_unit
    import fetch_mem_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0,
    parameter int PC_INC   = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              fetch_req,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              pc_write,
    input  logic [ADDR_W-1:0] pc_new,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    // counter only needs to reach MAX_WAIT-1; the next ack-less cycle is the timeout
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    fm_state_e         state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pc_inc;
    logic              ack_edge;
    logic              timeout_hit;

    assign ack_edge    = mem_req_q && mem_ack;
    assign timeout_hit = (MAX_WAIT != 0) && mem_req_q && !mem_ack
                         && (cnt_q == CNT_W'(MAX_WAIT - 1));

    // next-state and datapath updates for the access FSM
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        pc_inc      = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    mem_addr_d = pc;
                    mem_we_d   = 1'b0;
                    mem_req_d  = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = FETCH_WAIT;
                end else if (data_req) begin
                    mem_addr_d  = data_addr;
                    mem_we_d    = data_we;
                    mem_wdata_d = data_wdata;
                    mem_req_d   = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    state_d     = DATA_WAIT;
                end
            end
            FETCH_WAIT, DATA_WAIT: begin
                if (ack_edge) begin
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                    if (state_q == FETCH_WAIT) begin
                        ir_d   = mem_rdata;
                        pc_inc = 1'b1;
                    end else if (!mem_we_q) begin
                        mdr_d = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    err_d     = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (MAX_WAIT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // register all FSM state and outputs; reset aborts any access silently
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ir_q        <= '0;
            mdr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    pc_reg #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC),
        .PC_INC  (PC_INC)
    ) u_pc_reg (
        .clk     (CLK),
        .resetn  (RST_N),
        .load    (pc_write),
        .load_val(pc_new),
        .inc     (pc_inc),
        .pc      (pc)
    );

    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_fetch_mem_unit.sv
// tb/tb_fetch_mem_unit.sv - directed self-checking bench for fetch_mem_unit
module tb_fetch_mem_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        fetch_req, data_req, data_we, pc_write, mem_ack;
    logic [15:0] data_addr, data_wdata, pc_new, mem_rdata;
    logic [15:0] pc, ir, mdr, mem_addr, mem_wdata;
    logic        busy, done, err, mem_req, mem_we;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fetch_mem_unit #(
        .DATA_W(16), .ADDR_W(16), .RESET_PC(0), .PC_INC(2), .MAX_WAIT(15)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .fetch_req(fetch_req), .data_req(data_req), .data_we(data_we),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .pc_write(pc_write), .pc_new(pc_new),
        .pc(pc), .ir(ir), .mdr(mdr), .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        RST_N = 1'b0; fetch_req = 0; data_req = 0; data_we = 0; pc_write = 0; mem_ack = 0;
        data_addr = '0; data_wdata = '0; pc_new = '0; mem_rdata = '0;
        step(); step();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_mdr", mdr, 16'h0000);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_addr", mem_addr, 16'h0000);
        RST_N = 1'b1;

        // fetch with ack tied high: minimum two-cycle latency
        mem_ack = 1; mem_rdata = 16'hA5C3; fetch_req = 1;
        step();
        fetch_req = 0;
        chk("f1_req", mem_req, 1'b1);
        chk("f1_busy", busy, 1'b1);
        chk("f1_addr", mem_addr, 16'h0000);
        chk("f1_done_early", done, 1'b0);
        step();
        chk("f1_done", done, 1'b1);
        chk("f1_ir", ir, 16'hA5C3);
        chk("f1_pc", pc, 16'h0002);
        chk("f1_req_drop", mem_req, 1'b0);
        step();
        chk("f1_done_once", done, 1'b0);
        mem_ack = 0;

        // back to pc 0, then fetch with ack delayed five cycles
        pc_write = 1; pc_new = 16'h0000;
        step();
        pc_write = 0;
        chk("pcw_zero", pc, 16'h0000);
        fetch_req = 1; mem_rdata = 16'h1111;
        step();
        fetch_req = 0;
        for (int i = 0; i < 5; i++) begin
            chk("f2_req_hold", mem_req, 1'b1);
            chk("f2_addr_hold", mem_addr, 16'h0000);
            chk("f2_busy", busy, 1'b1);
            chk("f2_no_done", done, 1'b0);
            if (i == 4) mem_ack = 1;
            step();
        end
        chk("f2_done", done, 1'b1);
        chk("f2_ir", ir, 16'h1111);
        chk("f2_pc", pc, 16'h0002);
        mem_ack = 0;
        step();
        chk("f2_done_once", done, 1'b0);

        // data read then data write
        data_req = 1; data_we = 0; data_addr = 16'h0100; mem_rdata = 16'h1234; mem_ack = 1;
        step();
        data_req = 0;
        chk("rd_req", mem_req, 1'b1);
        chk("rd_we", mem_we, 1'b0);
        chk("rd_addr", mem_addr, 16'h0100);
        step();
        chk("rd_done", done, 1'b1);
        chk("rd_mdr", mdr, 16'h1234);
        chk("rd_pc", pc, 16'h0002);
        mem_ack = 0;
        data_req = 1; data_we = 1; data_addr = 16'h0102; data_wdata = 16'hBEEF; mem_rdata = 16'hDEAD;
        step();
        data_req = 0; data_we = 0;
        chk("wr_we", mem_we, 1'b1);
        chk("wr_wdata", mem_wdata, 16'hBEEF);
        chk("wr_addr", mem_addr, 16'h0102);
        mem_ack = 1;
        step();
        chk("wr_done", done, 1'b1);
        chk("wr_mdr", mdr, 16'h1234);
        chk("wr_pc", pc, 16'h0002);
        chk("wr_req_drop", mem_req, 1'b0);
        mem_ack = 0;

        // simultaneous requests: fetch wins; requests while busy are ignored
        fetch_req = 1; data_req = 1; data_addr = 16'h0200;
        step();
        fetch_req = 0; data_req = 0;
        chk("pri_addr", mem_addr, 16'h0002);
        chk("pri_we", mem_we, 1'b0);
        fetch_req = 1; data_req = 1; data_addr = 16'h0300;
        step();
        fetch_req = 0; data_req = 0;
        chk("busy_ign_addr", mem_addr, 16'h0002);
        chk("busy_ign_busy", busy, 1'b1);
        mem_ack = 1; mem_rdata = 16'h7777;
        step();
        chk("pri_done", done, 1'b1);
        chk("pri_ir", ir, 16'h7777);
        chk("pri_pc", pc, 16'h0004);
        mem_ack = 0;
        step();
        chk("pri_single_done", done, 1'b0);
        chk("pri_no_reissue", mem_req, 1'b0);

        // timeout: mem_req held 15 cycles, then err
        fetch_req = 1; mem_rdata = 16'hFFFF;
        step();
        fetch_req = 0;
        for (int i = 0; i < 15; i++) begin
            chk("to_req_hold", mem_req, 1'b1);
            chk("to_no_err", err, 1'b0);
            step();
        end
        chk("to_err", err, 1'b1);
        chk("to_req_drop", mem_req, 1'b0);
        chk("to_busy", busy, 1'b0);
        chk("to_no_done", done, 1'b0);
        chk("to_pc", pc, 16'h0004);
        chk("to_ir", ir, 16'h7777);
        chk("to_mdr", mdr, 16'h1234);
        step();
        chk("to_err_once", err, 1'b0);
        mem_ack = 1; mem_rdata = 16'h4242; fetch_req = 1;
        step();
        fetch_req = 0;
        step();
        chk("to_next_done", done, 1'b1);
        chk("to_next_ir", ir, 16'h4242);
        chk("to_next_pc", pc, 16'h0006);

        // pc wraps at the top of the address space
        pc_write = 1; pc_new = 16'hFFFE;
        step();
        pc_write = 0;
        fetch_req = 1; mem_rdata = 16'h0001;
        step();
        fetch_req = 0;
        chk("wrap_addr", mem_addr, 16'hFFFE);
        step();
        chk("wrap_done", done, 1'b1);
        chk("wrap_pc", pc, 16'h0000);

        // pc_write on the ack edge overrides the increment
        fetch_req = 1; mem_rdata = 16'h0002;
        step();
        fetch_req = 0;
        pc_write = 1; pc_new = 16'h0040;
        step();
        pc_write = 0;
        chk("pcw_ack_pc", pc, 16'h0040);
        chk("pcw_ack_ir", ir, 16'h0002);
        chk("pcw_ack_done", done, 1'b1);

        // reset mid-access aborts without done
        mem_ack = 0; fetch_req = 1;
        step();
        fetch_req = 0;
        chk("ra_req", mem_req, 1'b1);
        RST_N = 1'b0;
        step();
        chk("ra_req_drop", mem_req, 1'b0);
        chk("ra_busy", busy, 1'b0);
        chk("ra_done", done, 1'b0);
        chk("ra_pc", pc, 16'h0000);
        RST_N = 1'b1; mem_ack = 1;
        step();
        chk("ra_no_done", done, 1'b0);
        chk("ra_no_err", err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_mem_unit.md
Name: fetch_mem_unit

Overview:
Parametrised successor to the processor's fetch/memory datapath. It holds the PC, IR and MDR, and applies the instruction-or-data address select internally. It drives a variable-latency memory port through a req/ack handshake. The multi-cycle control FSM issues fetch or data-access commands and receives a one-cycle done or err pulse when each access finishes.

Parameters:
DATA_W, 16, instruction/data word width
ADDR_W, 16, memory address width
RESET_PC, 0, PC value after reset
PC_INC, 2, PC increment applied on each successful fetch
MAX_WAIT, 15, number of ack-less cycles before timeout; 0 disables the timeout

Ports:
CLK  in  1  clock; all state updates on its rising edge
RST_N  in  1  synchronous active-low reset
fetch_req  in  1  start an instruction fetch at the current pc
data_req  in  1  start a data access at data_addr (the ALUOut path)
data_we  in  1  data access direction: 1 = write, 0 = read
data_addr  in  ADDR_W  data access address
data_wdata  in  DATA_W  data to be written
pc_write  in  1  load pc_new into the PC
pc_new  in  ADDR_W  new PC value
pc  out  ADDR_W  current PC
ir  out  DATA_W  instruction register
mdr  out  DATA_W  memory data register
busy  out  1  high while an access is outstanding
done  out  1  one-cycle pulse when an access completes
err  out  1  one-cycle pulse when an access times out
mem_req  out  1  memory request, held until acknowledged
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory acknowledge (completes a write, or qualifies mem_rdata on a read)
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (RST_N low at an edge):
  - pc = RESET_PC; ir, mdr, mem_addr, mem_wdata, timeout counter = 0.
  - mem_req, mem_we, busy, done, err = 0; state = IDLE.
  - A reset during an access aborts it: mem_req drops at that edge and no done or err is issued.
- FSM states: IDLE, FETCH_WAIT, DATA_WAIT.
- IDLE:
  - fetch_req=1: latch mem_addr=pc, mem_we=0; set mem_req=1, busy=1; go to FETCH_WAIT.
  - Otherwise data_req=1: latch mem_addr=data_addr, mem_we=data_we, mem_wdata=data_wdata; set mem_req=1, busy=1; go to DATA_WAIT.
  - fetch_req has priority when both are high; the data_req is dropped, and the controller must re-issue it.
- While busy:
  - fetch_req and data_req are ignored.
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until the ack edge.
- Ack edge (mem_req=1 and mem_ack=1):
  - mem_req=0, busy=0, done=1 for exactly one cycle; return to IDLE.
  - FETCH_WAIT: ir <= mem_rdata; pc <= pc + PC_INC, modulo 2^ADDR_W.
  - DATA_WAIT read: mdr <= mem_rdata.
  - DATA_WAIT write: mdr unchanged.
- Latency: request sampled at edge N, mem_req high from N+1; if mem_ack is high in that cycle, done is high in cycle N+2. Minimum is 2 cycles.
- Back-to-back: a new request may be accepted in the cycle where done=1, because the FSM is already in IDLE.
- mem_ack while mem_req=0 is ignored.
- Timeout (MAX_WAIT>0):
  - The counter increments each cycle with mem_req=1 and mem_ack=0.
  - When the counter reaches MAX_WAIT: mem_req=0, busy=0, err=1 for one cycle; return to IDLE.
  - pc, ir and mdr are unchanged; the counter clears.
  - The counter also clears on every new request.
- pc_write:
  - Honoured in any state and overrides the fetch auto-increment if both occur at the same edge.
  - A fetch already in flight keeps its latched mem_addr.
- ir and mdr hold their values between loads; they do not update every cycle.
- done and err are never high together.

Decomposition:
- Package fetch_mem_pkg:
  - state enum (IDLE, FETCH_WAIT, DATA_WAIT).
  - Instruction field positions for the 16-bit encoding: control, RegA, RegB, RegD, immediate. These are used by the decode logic downstream, not inside this block.
- Sub-module pc_reg(ADDR_W, RESET_PC, PC_INC):
  - synchronous reset, load, increment.
  - Priority: reset > load > increment.

Test Plan:
- Reset, then fetch_req with mem_ack tied high and mem_rdata=16'hA5C3 -> done at cycle N+2, ir=16'hA5C3, pc=0x0002.
- Fetch with ack delayed 5 cycles -> mem_req and mem_addr=0x0000 held for 5 cycles, busy=1 throughout, done exactly once, ir loaded.
- Data read at data_addr=0x0100 returning 16'h1234, then data write of 16'hBEEF to 0x0102 -> mdr=0x1234 after the read and unchanged after the write; mem_we=1 and mem_wdata=0xBEEF during the write; pc unchanged.
- fetch_req and data_req in the same cycle, followed by fetch_req mid-access -> only the fetch is issued, the request made while busy is ignored, a single done.
- mem_ack never asserted with MAX_WAIT=15 -> err pulse after 15 wait cycles, mem_req drops, pc, ir and mdr unchanged, next fetch succeeds.
- pc=0xFFFE at fetch completion -> pc wraps to 0x0000. Separately, pc_write=1 with pc_new=0x0040 on the ack edge -> pc=0x0040. Separately, RST_N low mid-access -> mem_req=0 and no done.
